// File: rtl/generador_frec_pkg.sv
// generador_frec shared definitions.
// FSM state encoding and the minimum half-period.
package generador_frec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } estado_t;

    localparam int unsigned H_MIN = 1;

endpackage

// File: rtl/generador_frec_contador_fase.sv
// Loadable phase down-counter for generador_frec.
// Shared by the HIGH and LOW phases; zero marks phase end.
module contador_fase #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] r_value;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (en && (r_value != '0)) begin
            r_value <= r_value - CNT_WIDTH'(1);
        end
    end

    assign value = r_value;
    assign zero  = (r_value == '0);

endmodule

// File: rtl/generador_frec.sv
// Programmable square-wave generator (burst or continuous).
// FSM, latched H/N, completed-period counter, registered outputs.
module generador_frec
    import generador_frec_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int NCYC_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  half_period,
    input  logic [NCYC_WIDTH-1:0] n_cycles,
    output logic                  clock_out,
    output logic                  busy,
    output logic                  done,
    output logic [NCYC_WIDTH-1:0] cycles_out
);

    estado_t               r_state;
    logic [CNT_WIDTH-1:0]  r_h;
    logic [NCYC_WIDTH-1:0] r_n;
    logic [NCYC_WIDTH-1:0] r_cycles;
    logic                  r_clk;
    logic                  r_done;

    logic                  w_run;
    logic                  w_accept;
    logic                  w_phase_end;
    logic                  w_load;
    logic [CNT_WIDTH-1:0]  w_h_eff;
    logic [CNT_WIDTH-1:0]  w_load_value;
    logic [CNT_WIDTH-1:0]  w_cnt_value;
    logic                  w_cnt_zero;
    logic [NCYC_WIDTH-1:0] w_cycles_nxt;

    assign w_h_eff = (half_period < CNT_WIDTH'(H_MIN))
                   ? CNT_WIDTH'(H_MIN) : half_period;

    assign w_run        = (r_state == ST_HIGH) || (r_state == ST_LOW);
    assign w_accept     = (r_state == ST_IDLE) && start && !stop;
    assign w_phase_end  = w_run && w_cnt_zero && !stop;
    assign w_load       = w_accept || w_phase_end;
    assign w_load_value = w_accept ? (w_h_eff - CNT_WIDTH'(1))
                                   : (r_h - CNT_WIDTH'(1));
    assign w_cycles_nxt = r_cycles + NCYC_WIDTH'(1);

    contador_fase #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fase (
        .clock      (clock),
        .reset      (reset),
        .load       (w_load),
        .en         (w_run),
        .load_value (w_load_value),
        .value      (w_cnt_value),
        .zero       (w_cnt_zero)
    );

    // Sequencer: phase switching, period counting, burst end and abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_h      <= CNT_WIDTH'(H_MIN);
            r_n      <= '0;
            r_cycles <= '0;
            r_clk    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_h      <= w_h_eff;
                        r_n      <= n_cycles;
                        r_cycles <= '0;
                        r_clk    <= 1'b1;
                        r_state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (stop) begin
                        r_clk   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_cnt_zero) begin
                        r_clk   <= 1'b0;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (stop) begin
                        r_clk   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_cnt_zero) begin
                        r_cycles <= w_cycles_nxt;
                        if ((r_n != '0) && (w_cycles_nxt == r_n)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_clk   <= 1'b1;
                            r_state <= ST_HIGH;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_clk   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign clock_out  = r_clk;
    assign busy       = w_run;
    assign done       = r_done;
    assign cycles_out = r_cycles;

endmodule

// File: tb/tb_generador_frec.sv
// Self-checking bench for generador_frec.
// Reference model derives outputs from elapsed clocks since start.
module tb_generador_frec;

    localparam int CW = 32;
    localparam int NW = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic          stop;
    logic [CW-1:0] half_period;
    logic [NW-1:0] n_cycles;
    logic          clock_out;
    logic          busy;
    logic          done;
    logic [NW-1:0] cycles_out;

    int checks   = 0;
    int failures = 0;

    generador_frec #(
        .CNT_WIDTH  (CW),
        .NCYC_WIDTH (NW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .half_period(half_period),
        .n_cycles   (n_cycles),
        .clock_out  (clock_out),
        .busy       (busy),
        .done       (done),
        .cycles_out (cycles_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs,
                       input longint exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected outputs e clocks after the accepting edge (n=0: endless).
    task automatic check_model(input string tag, input longint e,
                               input longint h, input longint n);
        longint len;
        longint ec;
        longint eb;
        longint ed;
        longint ey;
        len = 2 * h * n;
        if (n == 0 || e < len) begin
            ec = ((e / h) % 2 == 0) ? 1 : 0;
            eb = 1;
            ed = 0;
            ey = (e / (2 * h)) % (64'd1 << NW);
        end else begin
            ec = 0;
            eb = 0;
            ed = (e == len) ? 1 : 0;
            ey = n;
        end
        chk({tag, ".clk"},    longint'(clock_out),  ec);
        chk({tag, ".busy"},   longint'(busy),       eb);
        chk({tag, ".done"},   longint'(done),       ed);
        chk({tag, ".cycles"}, longint'(cycles_out), ey);
    endtask

    // Launch a burst and follow it to idle, optionally poking
    // start/half_period/n_cycles mid-run.
    task automatic run_burst(input string tag, input int hp, input int n,
                             input bit noisy);
        longint h;
        longint len;
        h = (hp < 1) ? 1 : hp;
        len = 2 * h * n;
        @(negedge clock);
        half_period = CW'(hp);
        n_cycles    = NW'(n);
        start       = 1'b1;
        for (longint e = 0; e <= len + 1; e++) begin
            @(negedge clock);
            check_model(tag, e, h, n);
            if (noisy && e < len) begin
                start       = 1'($urandom_range(0, 1));
                half_period = CW'($urandom_range(0, 9));
                n_cycles    = NW'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int rises;
        bit prev;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        half_period = '0;
        n_cycles    = '0;
        #3;
        chk("rst.clk",    longint'(clock_out),  0);
        chk("rst.busy",   longint'(busy),       0);
        chk("rst.done",   longint'(done),       0);
        chk("rst.cycles", longint'(cycles_out), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_burst("h3n2", 3, 2, 1'b0);
        run_burst("h0n4", 0, 4, 1'b0);
        run_burst("h2n3busy", 2, 3, 1'b1);

        // start together with stop must be refused
        @(negedge clock);
        half_period = 2;
        n_cycles    = 1;
        start       = 1'b1;
        stop        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop.busy", longint'(busy),      0);
        chk("startstop.clk",  longint'(clock_out), 0);

        for (int i = 0; i < 12; i++) begin
            run_burst($sformatf("rnd%0d", i),
                      int'($urandom_range(0, 5)),
                      int'($urandom_range(1, 4)),
                      1'b1);
        end

        // continuous, stop after five periods
        @(negedge clock);
        half_period = 2;
        n_cycles    = 0;
        start       = 1'b1;
        for (longint e = 0; e <= 20; e++) begin
            @(negedge clock);
            start = 1'b0;
            check_model("cont", e, 2, 0);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        chk("stop.clk",    longint'(clock_out),  0);
        chk("stop.busy",   longint'(busy),       0);
        chk("stop.done",   longint'(done),       0);
        chk("stop.cycles", longint'(cycles_out), 5);
        @(negedge clock);
        chk("stop.done2",   longint'(done),       0);
        chk("stop.cycles2", longint'(cycles_out), 5);

        // async reset in the HIGH phase
        half_period = 5;
        n_cycles    = 3;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("prerst.clk", longint'(clock_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.clk",    longint'(clock_out),  0);
        chk("arst.busy",   longint'(busy),       0);
        chk("arst.done",   longint'(done),       0);
        chk("arst.cycles", longint'(cycles_out), 0);
        @(negedge clock);
        reset = 1'b0;
        run_burst("postrst", 3, 2, 1'b0);

        // loopback: count rising edges over 256 clocks at H=4
        @(negedge clock);
        half_period = 4;
        n_cycles    = 0;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        prev  = clock_out;
        rises = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (clock_out && !prev) rises++;
            prev = clock_out;
        end
        chk("loop.range",
            longint'((rises >= 31 && rises <= 33) ? 1 : 0), 1);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        chk("loop.stopped", longint'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
